// File: rtl/rx_frame_buffer.sv
// Receive frame store: buffers deframer bytes in a circular RAM, commits frames
// closing with good FCS into a length FIFO, and rewinds everything else.
module rx_frame_buffer #(
  parameter int ADDR_W = 9,
  parameter int LEN_AW = 2
) (
  input  logic            netclk,
  input  logic            reset_n,
  input  logic            byte_ready,
  input  logic [7:0]      din,
  input  logic            frame_complete,
  input  logic            frame_valid,
  input  logic            frame_abort,
  output logic            frame_avail,
  output logic [ADDR_W:0] frame_len,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  input  logic            frame_ack,
  output logic [7:0]      drop_count,
  output logic            overflow
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LDEPTH = 1 << LEN_AW;
  localparam logic [ADDR_W:0] FULL_USED = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] MIN_LEN   = (ADDR_W+1)'(3);
  localparam logic [ADDR_W:0] FCS_LEN   = (ADDR_W+1)'(2);
  localparam logic [LEN_AW:0] LF_FULL   = (LEN_AW+1)'(LDEPTH);

  logic            r_byte_q, r_cmp_q, r_abt_q;
  logic [ADDR_W:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_rd_base, r_cur_len;
  logic            r_ovf, r_overflow, r_frame_avail, r_ack_q;
  logic [ADDR_W:0] r_frame_len;
  logic [7:0]      r_drop_count, r_rd_data;
  logic [LEN_AW:0] r_lf_wr, r_lf_rd;
  logic [ADDR_W:0] r_len_mem [LDEPTH];
  logic [7:0]      r_mem [DEPTH];

  logic            w_byte_ev, w_cmp_ev, w_abt_ev;
  logic [ADDR_W:0] w_used, w_rd_off, w_len_eff, w_lf_head;
  logic            w_full, w_byte_wr, w_byte_drop, w_ovf_eff;
  logic            w_close, w_idle_close, w_lf_full, w_lf_empty;
  logic            w_commit, w_discard, w_host_ok, w_ack, w_rd;

  assign w_byte_ev = byte_ready & ~r_byte_q;
  assign w_cmp_ev  = frame_complete & ~r_cmp_q;
  assign w_abt_ev  = frame_abort & ~r_abt_q;

  // Space is measured against rd_base, so the head frame stays protected until acked.
  assign w_used      = r_wr_ptr - r_rd_base;
  assign w_full      = (w_used == FULL_USED);
  assign w_byte_wr   = w_byte_ev & ~w_full & ~r_ovf;
  assign w_byte_drop = w_byte_ev & ~w_byte_wr;
  assign w_len_eff   = r_cur_len + {{ADDR_W{1'b0}}, w_byte_wr};
  assign w_ovf_eff   = r_ovf | w_byte_drop;

  assign w_lf_empty = (r_lf_wr == r_lf_rd);
  assign w_lf_full  = ((r_lf_wr - r_lf_rd) == LF_FULL);
  assign w_lf_head  = r_len_mem[r_lf_rd[LEN_AW-1:0]];

  // A flag with nothing stored and nothing lost is a back-to-back flag: ignore it.
  assign w_close      = w_cmp_ev | w_abt_ev;
  assign w_idle_close = (w_len_eff == '0) & ~w_ovf_eff;
  assign w_commit     = w_close & ~w_idle_close & ~w_abt_ev & frame_valid & ~w_ovf_eff
                      & (w_len_eff >= MIN_LEN) & ~w_lf_full;
  assign w_discard    = w_close & ~w_idle_close & ~w_commit;

  // Host ops pause for the one cycle in which frame_len still shows the acked frame.
  assign w_host_ok = r_frame_avail & ~r_ack_q;
  assign w_ack     = frame_ack & w_host_ok;
  assign w_rd_off  = r_rd_ptr - r_rd_base;
  assign w_rd      = rd_en & w_host_ok & ~w_ack & (w_rd_off < r_frame_len);

  // NOTE: every register in a clocked block uses <= so all of them update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge netclk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_q      <= 1'b0;
      r_cmp_q       <= 1'b0;
      r_abt_q       <= 1'b0;
      r_wr_ptr      <= '0;
      r_commit_ptr  <= '0;
      r_rd_ptr      <= '0;
      r_rd_base     <= '0;
      r_cur_len     <= '0;
      r_ovf         <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_avail <= 1'b0;
      r_frame_len   <= '0;
      r_ack_q       <= 1'b0;
      r_drop_count  <= '0;
      r_rd_data     <= '0;
      r_lf_wr       <= '0;
      r_lf_rd       <= '0;
    end else begin
      r_byte_q <= byte_ready;
      r_cmp_q  <= frame_complete;
      r_abt_q  <= frame_abort;

      if (w_discard)      r_wr_ptr <= r_commit_ptr;
      else if (w_byte_wr) r_wr_ptr <= r_wr_ptr + 1'b1;

      if (w_close && !w_idle_close) begin
        r_cur_len <= '0;
        r_ovf     <= 1'b0;
      end else begin
        r_cur_len <= w_len_eff;
        r_ovf     <= w_ovf_eff;
      end
      if (w_byte_drop) r_overflow <= 1'b1;

      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr + {{ADDR_W{1'b0}}, w_byte_wr};
        r_lf_wr      <= r_lf_wr + 1'b1;
      end
      if (w_discard && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;

      if (w_ack) begin
        r_rd_base <= r_rd_base + r_frame_len + FCS_LEN;
        r_rd_ptr  <= r_rd_base + r_frame_len + FCS_LEN;
        r_lf_rd   <= r_lf_rd + 1'b1;
      end else if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
      end
      r_ack_q <= w_ack;

      r_frame_avail <= ~w_lf_empty;
      r_frame_len   <= w_lf_empty ? '0 : w_lf_head;
    end
  end

  // NOTE: the byte RAM and length FIFO storage carry no reset; the pointers
  // alone define which entries are meaningful.
  always_ff @(posedge netclk) begin
    if (w_byte_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
    if (w_commit)  r_len_mem[r_lf_wr[LEN_AW-1:0]] <= w_len_eff - FCS_LEN;
  end

  assign frame_avail = r_frame_avail;
  assign frame_len   = r_frame_len;
  assign rd_data     = r_rd_data;
  assign drop_count  = r_drop_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: a default-size instance and a 16-byte
// instance share stimulus so the small one can be driven into overflow.
module tb_rx_frame_buffer;
  logic       netclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       byte_ready = 1'b0, frame_complete = 1'b0, frame_valid = 1'b0, frame_abort = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd_en = 1'b0, frame_ack = 1'b0;

  logic       m_frame_avail, m_overflow;
  logic [9:0] m_frame_len;
  logic [7:0] m_rd_data, m_drop_count;
  logic       s_frame_avail, s_overflow;
  logic [4:0] s_frame_len;
  logic [7:0] s_rd_data, s_drop_count;

  int total = 0;
  int bad = 0;

  always #5 netclk = ~netclk;

  rx_frame_buffer dut_m (
    .netclk(netclk), .reset_n(reset_n), .byte_ready(byte_ready), .din(din),
    .frame_complete(frame_complete), .frame_valid(frame_valid), .frame_abort(frame_abort),
    .frame_avail(m_frame_avail), .frame_len(m_frame_len), .rd_en(rd_en), .rd_data(m_rd_data),
    .frame_ack(frame_ack), .drop_count(m_drop_count), .overflow(m_overflow)
  );

  rx_frame_buffer #(.ADDR_W(4), .LEN_AW(2)) dut_s (
    .netclk(netclk), .reset_n(reset_n), .byte_ready(byte_ready), .din(din),
    .frame_complete(frame_complete), .frame_valid(frame_valid), .frame_abort(frame_abort),
    .frame_avail(s_frame_avail), .frame_len(s_frame_len), .rd_en(rd_en), .rd_data(s_rd_data),
    .frame_ack(frame_ack), .drop_count(s_drop_count), .overflow(s_overflow)
  );

  task automatic do_reset();
    @(negedge netclk);
    reset_n = 1'b0;
    repeat (2) @(negedge netclk);
    reset_n = 1'b1;
    @(negedge netclk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge netclk);
    byte_ready = 1'b1;
    din = b;
    @(negedge netclk);
    byte_ready = 1'b0;
  endtask

  // Leaves the caller one edge after the commit edge, where frame_avail is valid.
  task automatic send_complete(input logic valid);
    @(negedge netclk);
    frame_complete = 1'b1;
    frame_valid = valid;
    @(negedge netclk);
    frame_complete = 1'b0;
    frame_valid = 1'b0;
    @(negedge netclk);
  endtask

  task automatic send_abort();
    @(negedge netclk);
    frame_abort = 1'b1;
    @(negedge netclk);
    frame_abort = 1'b0;
    @(negedge netclk);
  endtask

  task automatic read_byte(output logic [7:0] m, output logic [7:0] s);
    @(negedge netclk);
    rd_en = 1'b1;
    @(negedge netclk);
    rd_en = 1'b0;
    @(negedge netclk);
    m = m_rd_data;
    s = s_rd_data;
  endtask

  task automatic do_ack();
    @(negedge netclk);
    frame_ack = 1'b1;
    @(negedge netclk);
    frame_ack = 1'b0;
    @(negedge netclk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (m_frame_avail !== 1'b0) begin bad++; $display("FAIL reset_avail got=%0d want=0", m_frame_avail); end
    total++; if (m_frame_len !== 10'd0) begin bad++; $display("FAIL reset_len got=%0d want=0", m_frame_len); end
    total++; if (m_rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", m_rd_data); end
    total++; if (m_drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", m_drop_count); end
    total++; if (m_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0d want=0", m_overflow); end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp_b [5] = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h5A};
    logic [7:0] m, s;
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(exp_b[i]);
    send_complete(1'b1);
    total++; if (m_frame_avail !== 1'b1) begin bad++; $display("FAIL good_avail got=%0d want=1", m_frame_avail); end
    total++; if (m_frame_len !== 10'd3) begin bad++; $display("FAIL good_len got=%0d want=3", m_frame_len); end
    for (int i = 0; i < 3; i++) begin
      read_byte(m, s);
      total++; if (m !== exp_b[i]) begin bad++; $display("FAIL good_data[%0d] got=%h want=%h", i, m, exp_b[i]); end
    end
    // A fourth read is beyond frame_len and must leave rd_data unchanged.
    read_byte(m, s);
    total++; if (m !== 8'h33) begin bad++; $display("FAIL good_read_past_len got=%h want=33", m); end
    do_ack();
    total++; if (m_frame_avail !== 1'b0) begin bad++; $display("FAIL good_avail_after_ack got=%0d want=0", m_frame_avail); end
    total++; if ((dut_m.r_wr_ptr - dut_m.r_rd_base) !== 10'd0) begin bad++; $display("FAIL good_used_after_ack got=%0d want=0", dut_m.r_wr_ptr - dut_m.r_rd_base); end
  endtask

  task automatic test_bad_then_good();
    logic [7:0] m, s;
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'h90 + 8'(i));
    send_complete(1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'hC1 + 8'(i));
    send_complete(1'b1);
    total++; if (m_drop_count !== 8'd1) begin bad++; $display("FAIL badfcs_drop got=%0d want=1", m_drop_count); end
    total++; if (m_frame_avail !== 1'b1) begin bad++; $display("FAIL badfcs_avail got=%0d want=1", m_frame_avail); end
    total++; if (m_frame_len !== 10'd2) begin bad++; $display("FAIL badfcs_len got=%0d want=2", m_frame_len); end
    read_byte(m, s);
    total++; if (m !== 8'hC1) begin bad++; $display("FAIL badfcs_first_byte got=%h want=c1", m); end
    do_ack();
    total++; if (m_frame_avail !== 1'b0) begin bad++; $display("FAIL badfcs_only_one got=%0d want=0", m_frame_avail); end
  endtask

  task automatic test_abort_runt();
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h31 + 8'(i));
    send_abort();
    send_byte(8'h41);
    send_byte(8'h42);
    send_complete(1'b1);
    // Back-to-back flag with nothing stored must not be counted.
    send_complete(1'b1);
    total++; if (m_drop_count !== 8'd2) begin bad++; $display("FAIL abort_drop got=%0d want=2", m_drop_count); end
    total++; if (m_frame_avail !== 1'b0) begin bad++; $display("FAIL abort_avail got=%0d want=0", m_frame_avail); end
    total++; if (dut_m.r_wr_ptr !== 10'd0) begin bad++; $display("FAIL abort_wr_ptr got=%0d want=0", dut_m.r_wr_ptr); end
    total++; if (dut_m.r_commit_ptr !== 10'd0) begin bad++; $display("FAIL abort_commit_ptr got=%0d want=0", dut_m.r_commit_ptr); end
  endtask

  task automatic test_overflow();
    logic [7:0] m, s;
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(8'h01 + 8'(i));
    send_complete(1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i));
    send_complete(1'b1);
    total++; if (s_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d want=1", s_overflow); end
    total++; if (s_drop_count !== 8'd1) begin bad++; $display("FAIL ovf_drop got=%0d want=1", s_drop_count); end
    total++; if (s_frame_len !== 5'd8) begin bad++; $display("FAIL ovf_len got=%0d want=8", s_frame_len); end
    total++; if (m_overflow !== 1'b0) begin bad++; $display("FAIL ovf_big_flag got=%0d want=0", m_overflow); end
    total++; if (m_drop_count !== 8'd0) begin bad++; $display("FAIL ovf_big_drop got=%0d want=0", m_drop_count); end
    for (int i = 0; i < 8; i++) begin
      read_byte(m, s);
      total++; if (s !== 8'h01 + 8'(i)) begin bad++; $display("FAIL ovf_data[%0d] got=%h want=%h", i, s, 8'h01 + 8'(i)); end
    end
    do_ack();
    total++; if (s_frame_avail !== 1'b0) begin bad++; $display("FAIL ovf_small_empty got=%0d want=0", s_frame_avail); end
    total++; if (m_frame_avail !== 1'b1 || m_frame_len !== 10'd8) begin bad++; $display("FAIL ovf_big_second got=%0d/%0d want=1/8", m_frame_avail, m_frame_len); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] m, s;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      send_byte(8'h40 + 8'(f));
      send_byte(8'hE0);
      send_byte(8'hE1);
      send_complete(1'b1);
    end
    total++; if (m_drop_count !== 8'd1) begin bad++; $display("FAIL fifo_drop got=%0d want=1", m_drop_count); end
    for (int f = 0; f < 4; f++) begin
      total++; if (m_frame_avail !== 1'b1) begin bad++; $display("FAIL fifo_avail[%0d] got=%0d want=1", f, m_frame_avail); end
      total++; if (m_frame_len !== 10'd1) begin bad++; $display("FAIL fifo_len[%0d] got=%0d want=1", f, m_frame_len); end
      read_byte(m, s);
      total++; if (m !== 8'h40 + 8'(f)) begin bad++; $display("FAIL fifo_data[%0d] got=%h want=%h", f, m, 8'h40 + 8'(f)); end
      do_ack();
    end
    total++; if (m_frame_avail !== 1'b0) begin bad++; $display("FAIL fifo_empty got=%0d want=0", m_frame_avail); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] m, s;
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h50);
    send_complete(1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i));
    send_complete(1'b1);
    read_byte(m, s);
    send_byte(8'hAB);
    @(negedge netclk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (m_frame_avail !== 1'b0) begin bad++; $display("FAIL midrst_avail got=%0d want=0", m_frame_avail); end
    total++; if (m_frame_len !== 10'd0) begin bad++; $display("FAIL midrst_len got=%0d want=0", m_frame_len); end
    total++; if (m_rd_data !== 8'h00) begin bad++; $display("FAIL midrst_rd_data got=%h want=00", m_rd_data); end
    total++; if (m_drop_count !== 8'd0) begin bad++; $display("FAIL midrst_drop got=%0d want=0", m_drop_count); end
    @(negedge netclk);
    reset_n = 1'b1;
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    send_byte(8'hF0);
    send_complete(1'b1);
    total++; if (m_frame_avail !== 1'b1 || m_frame_len !== 10'd2) begin bad++; $display("FAIL midrst_commit got=%0d/%0d want=1/2", m_frame_avail, m_frame_len); end
    read_byte(m, s);
    total++; if (m !== 8'h77) begin bad++; $display("FAIL midrst_data0 got=%h want=77", m); end
    read_byte(m, s);
    total++; if (m !== 8'h88) begin bad++; $display("FAIL midrst_data1 got=%h want=88", m); end
    total++; if (m_drop_count !== 8'd0) begin bad++; $display("FAIL midrst_drop_after got=%0d want=0", m_drop_count); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_then_good();
    test_abort_runt();
    test_overflow();
    test_fifo_full();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
